// File: rtl/step_gen_pkg.sv
// ============================================================================
// Module : step_gen_pkg
// Brief  : Shared FSM state encodings and default widths for the step generator.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package step_gen_pkg;

    localparam int c_CNT_W_DEFAULT  = 16;
    localparam int c_PEND_W_DEFAULT = 8;
    localparam int c_POS_W_DEFAULT  = 32;

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_SETUP = 2'd1;
    localparam logic [1:0] c_ST_HIGH  = 2'd2;
    localparam logic [1:0] c_ST_LOW   = 2'd3;

endpackage

`default_nettype wire

// File: rtl/step_interval_timer.sv
// ============================================================================
// Module : step_interval_timer
// Brief  : Loadable down-counter; a load of 0 behaves as 1, o_done on last cycle.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module step_interval_timer
    import step_gen_pkg::*;
#(
    parameter int CNT_W = c_CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_value,
    output logic             o_done
);

    logic [CNT_W-1:0] r_cnt;

    // The count holds the cycles remaining after the current one.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= {CNT_W{1'b0}};
        end else if (i_load) begin
            r_cnt <= (i_value == {CNT_W{1'b0}}) ? {CNT_W{1'b0}} : i_value - 1'b1;
        end else if (r_cnt != {CNT_W{1'b0}}) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_done = (r_cnt == {CNT_W{1'b0}});

endmodule

`default_nettype wire

// File: rtl/step_pulse_scheduler.sv
// ============================================================================
// Module : step_pulse_scheduler
// Brief  : Queues step requests and emits STEP/DIR with setup/high/low timing.
//          Optional position counter: STEP_GEN_POSITION_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module step_pulse_scheduler
    import step_gen_pkg::*;
#(
    parameter int CNT_W  = c_CNT_W_DEFAULT,
    parameter int PEND_W = c_PEND_W_DEFAULT
`ifdef STEP_GEN_POSITION_EN
    ,
    parameter int POS_W  = c_POS_W_DEFAULT
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              step_req,
    input  logic              dir_req,
    input  logic              flush,
    input  logic              clr_overflow,
    input  logic [CNT_W-1:0]  setup_cyc,
    input  logic [CNT_W-1:0]  high_cyc,
    input  logic [CNT_W-1:0]  low_cyc,
    output logic              step_out,
    output logic              dir_out,
    output logic              busy,
    output logic [PEND_W-1:0] pending,
`ifdef STEP_GEN_POSITION_EN
    output logic [POS_W-1:0]  position,
`endif
    output logic              overflow
);

    logic [1:0]        r_state;
    logic              r_step;
    logic              r_dir;
    logic [PEND_W-1:0] r_pending;
    logic              r_ovf;

    logic [1:0]        w_next_state;
    logic              w_load;
    logic [CNT_W-1:0]  w_load_val;
    logic              w_enter_high;
    logic              w_set_dir;
    logic              w_done;
    logic              w_start;
    logic              w_dir_chg;
    logic              w_drop;

    assign w_start   = enable && (r_pending != {PEND_W{1'b0}});
    assign w_dir_chg = (dir_req != r_dir);

    step_interval_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_load),
        .i_value (w_load_val),
        .o_done  (w_done)
    );

    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_load_val   = high_cyc;
        w_enter_high = 1'b0;
        w_set_dir    = 1'b0;
        case (r_state)
            c_ST_IDLE, c_ST_LOW: begin
                // IDLE decides every cycle; LOW only on its final cycle.
                if ((r_state == c_ST_IDLE) || w_done) begin
                    if (w_start && w_dir_chg) begin
                        w_next_state = c_ST_SETUP;
                        w_load       = 1'b1;
                        w_load_val   = setup_cyc;
                        w_set_dir    = 1'b1;
                    end else if (w_start) begin
                        w_next_state = c_ST_HIGH;
                        w_load       = 1'b1;
                        w_load_val   = high_cyc;
                        w_enter_high = 1'b1;
                    end else begin
                        w_next_state = c_ST_IDLE;
                    end
                end
            end
            c_ST_SETUP: begin
                if (w_done) begin
                    w_next_state = c_ST_HIGH;
                    w_load       = 1'b1;
                    w_load_val   = high_cyc;
                    w_enter_high = 1'b1;
                end
            end
            c_ST_HIGH: begin
                if (w_done) begin
                    w_next_state = c_ST_LOW;
                    w_load       = 1'b1;
                    w_load_val   = low_cyc;
                end
            end
            default: begin
                w_next_state = c_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
            r_step  <= 1'b0;
            r_dir   <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_set_dir) begin
                r_dir <= dir_req;
            end
            if (w_enter_high) begin
                r_step <= 1'b1;
            end else if ((r_state == c_ST_HIGH) && w_done) begin
                r_step <= 1'b0;
            end
        end
    end

    // Flush wins over both a new request and the decrement of a starting step.
    assign w_drop = step_req && !w_enter_high && (&r_pending) && !flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending <= {PEND_W{1'b0}};
        end else if (flush) begin
            r_pending <= {PEND_W{1'b0}};
        end else if (step_req && !w_enter_high) begin
            if (!(&r_pending)) begin
                r_pending <= r_pending + 1'b1;
            end
        end else if (!step_req && w_enter_high) begin
            r_pending <= r_pending - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
        end else if (clr_overflow) begin
            r_ovf <= 1'b0;
        end
    end

`ifdef STEP_GEN_POSITION_EN
    logic [POS_W-1:0] r_pos;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pos <= {POS_W{1'b0}};
        end else if (w_enter_high) begin
            r_pos <= r_dir ? r_pos + 1'b1 : r_pos - 1'b1;
        end
    end

    assign position = r_pos;
`endif

    assign step_out = r_step;
    assign dir_out  = r_dir;
    assign busy     = (r_state != c_ST_IDLE);
    assign pending  = r_pending;
    assign overflow = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_step_pulse_scheduler.sv
// ============================================================================
// Module : tb_step_pulse_scheduler
// Brief  : Directed-vector bench for step_pulse_scheduler.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_step_pulse_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        step_req;
    logic        dir_req;
    logic        flush;
    logic        clr_overflow;
    logic [15:0] setup_cyc;
    logic [15:0] high_cyc;
    logic [15:0] low_cyc;

    logic        step_out,  dir_out,  busy,  overflow;
    logic [7:0]  pending;
    logic        step_out2, dir_out2, busy2, overflow2;
    logic [1:0]  pending2;
`ifdef STEP_GEN_POSITION_EN
    logic [31:0] position;
    logic [31:0] position2;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    step_pulse_scheduler #(.CNT_W(16), .PEND_W(8)) u_dut (
        .clk(clk), .rst(rst), .enable(enable), .step_req(step_req),
        .dir_req(dir_req), .flush(flush), .clr_overflow(clr_overflow),
        .setup_cyc(setup_cyc), .high_cyc(high_cyc), .low_cyc(low_cyc),
        .step_out(step_out), .dir_out(dir_out), .busy(busy),
        .pending(pending),
`ifdef STEP_GEN_POSITION_EN
        .position(position),
`endif
        .overflow(overflow)
    );

    step_pulse_scheduler #(.CNT_W(16), .PEND_W(2)) u_dut_small (
        .clk(clk), .rst(rst), .enable(enable), .step_req(step_req),
        .dir_req(dir_req), .flush(flush), .clr_overflow(clr_overflow),
        .setup_cyc(setup_cyc), .high_cyc(high_cyc), .low_cyc(low_cyc),
        .step_out(step_out2), .dir_out(dir_out2), .busy(busy2),
        .pending(pending2),
`ifdef STEP_GEN_POSITION_EN
        .position(position2),
`endif
        .overflow(overflow2)
    );

    typedef struct {
        logic        dir;
        logic [15:0] setup;
        logic [15:0] high;
        logic [15:0] low;
        int          exp_dir_k;
        int          exp_rise;
        int          exp_fall;
        int          exp_idle;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic queue_reqs(input int n);
        for (int i = 0; i < n; i++) begin
            step_req = 1'b1;
            tick();
            step_req = 1'b0;
            tick();
        end
    endtask

    int rise, fall, idle, dir_k, nrise;
    int rise_k [5];
    int rise_p [5];
    logic prev;

    initial begin
        rst = 1'b1; enable = 1'b0; step_req = 1'b0; dir_req = 1'b0;
        flush = 1'b0; clr_overflow = 1'b0;
        setup_cyc = 16'd1; high_cyc = 16'd1; low_cyc = 16'd1;

        // Offsets are relative to the cycle N in which step_req is high.
        vecs[0] = '{1'b0, 16'd5, 16'd3, 16'd2, 1, 2,  5,  7};
        vecs[1] = '{1'b1, 16'd4, 16'd1, 16'd1, 2, 6,  7,  8};
        vecs[2] = '{1'b1, 16'd0, 16'd0, 16'd0, 2, 3,  4,  5};
        vecs[3] = '{1'b0, 16'd0, 16'd0, 16'd0, 1, 2,  3,  4};
        vecs[4] = '{1'b1, 16'd1, 16'd5, 16'd3, 2, 3,  8, 11};
        vecs[5] = '{1'b0, 16'd9, 16'd2, 16'd7, 1, 2,  4, 11};

        do_reset();
        check("rst_step_out", step_out, 0);
        check("rst_dir_out",  dir_out,  0);
        check("rst_busy",     busy,     0);
        check("rst_pending",  pending,  0);
        check("rst_overflow", overflow, 0);
`ifdef STEP_GEN_POSITION_EN
        check("rst_position", position, 0);
`endif

        for (int v = 0; v < 6; v++) begin
            dir_req   = vecs[v].dir;
            setup_cyc = vecs[v].setup;
            high_cyc  = vecs[v].high;
            low_cyc   = vecs[v].low;
            enable    = 1'b1;
            do_reset();
            step_req = 1'b1;
            tick();
            step_req = 1'b0;
            check($sformatf("v%0d_pending_n1", v), pending, 1);
            rise = -1; fall = -1; idle = -1; dir_k = -1;
            for (int k = 1; k <= 30; k++) begin
                if (dir_k < 0 && dir_out == vecs[v].dir) dir_k = k;
                if (rise < 0 && step_out) rise = k;
                else if (rise >= 0 && fall < 0 && !step_out) fall = k;
                else if (fall >= 0 && idle < 0 && !busy) idle = k;
                tick();
            end
            check($sformatf("v%0d_dir_cycle", v), dir_k, vecs[v].exp_dir_k);
            check($sformatf("v%0d_rise", v), rise, vecs[v].exp_rise);
            check($sformatf("v%0d_fall", v), fall, vecs[v].exp_fall);
            check($sformatf("v%0d_idle", v), idle, vecs[v].exp_idle);
            check($sformatf("v%0d_pending_end", v), pending, 0);
`ifdef STEP_GEN_POSITION_EN
            check($sformatf("v%0d_position", v), position,
                  vecs[v].dir ? 32'd1 : 32'hFFFF_FFFF);
`endif
        end

        // Queue while disabled (also saturates the PEND_W=2 instance), then release.
        dir_req = 1'b0; setup_cyc = 16'd3; high_cyc = 16'd2; low_cyc = 16'd2;
        enable = 1'b0;
        do_reset();
        queue_reqs(5);
        check("q_pending",       pending,   5);
        check("q_overflow",      overflow,  0);
        check("q_busy",          busy,      0);
        check("sat_pending",     pending2,  3);
        check("sat_overflow",    overflow2, 1);
        clr_overflow = 1'b1;
        tick();
        clr_overflow = 1'b0;
        check("sat_overflow_clr", overflow2, 0);
        check("sat_pending_kept", pending2,  3);

        enable = 1'b1;
        nrise = 0; prev = 1'b0;
        for (int k = 0; k < 25; k++) begin
            if (step_out && !prev) begin
                if (nrise < 5) begin
                    rise_k[nrise] = k;
                    rise_p[nrise] = pending;
                end
                nrise++;
            end
            prev = step_out;
            tick();
        end
        check("burst_count", nrise, 5);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("burst_rise%0d", i),    rise_k[i], 1 + 4 * i);
            check($sformatf("burst_pending%0d", i), rise_p[i], 4 - i);
        end
        check("burst_idle", busy, 0);
`ifdef STEP_GEN_POSITION_EN
        check("burst_position", position, 32'hFFFF_FFFB);
`endif

        // Flush during HIGH, with a coincident request that must be discarded.
        high_cyc = 16'd4; low_cyc = 16'd2;
        enable = 1'b0;
        do_reset();
        queue_reqs(4);
        enable = 1'b1;
        tick();
        check("fl_step_k1",    step_out, 1);
        check("fl_pending_k1", pending,  3);
        tick();
        flush = 1'b1; step_req = 1'b1;
        tick();
        flush = 1'b0; step_req = 1'b0;
        check("fl_pending_k3", pending,  0);
        check("fl_step_k3",    step_out, 1);
        tick();
        check("fl_step_k4",    step_out, 1);
        tick();
        check("fl_step_k5",    step_out, 0);
        check("fl_busy_k5",    busy,     1);
        tick();
        tick();
        check("fl_busy_k7",    busy,     0);
        repeat (4) tick();
        check("fl_step_late",  step_out, 0);
        check("fl_busy_late",  busy,     0);

        // Reset aborts a pulse in progress.
        high_cyc = 16'd5; low_cyc = 16'd2;
        enable = 1'b0;
        do_reset();
        queue_reqs(3);
        enable = 1'b1;
        tick();
        tick();
        check("rh_step_high", step_out, 1);
        check("rh_pending",   pending,  2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rh_step_out",  step_out, 0);
        check("rh_busy",      busy,     0);
        check("rh_pending0",  pending,  0);
        enable = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
